// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one 128-bit state per handshake, COLS_PER_CYCLE columns per clock,
// result held on a valid/ready output until taken.
module inv_mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gen_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Element 0 is the MSB word, i.e. column 0.
  typedef logic [0:3][31:0] state_t;
  typedef enum logic [1:0] {StIdle, StBusy, StDone} st_e;

  localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LastIdx = 2'(4 - COLS_PER_CYCLE);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  st_e          state_q, state_d;
  state_t       work_q, work_d;
  logic [1:0]   col_idx_q, col_idx_d;
  logic [127:0] out_q, out_d;
  logic [1:0]   idx;

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    col_idx_d = col_idx_q;
    out_d     = out_q;
    idx       = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d    = state_in;
          col_idx_d = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        busy = 1'b1;
        for (int j = 0; j < int'(COLS_PER_CYCLE); j++) begin
          idx         = col_idx_q + 2'(j);
          work_d[idx] = inv_col(work_q[idx]);
        end
        col_idx_d = col_idx_q + ColStep;
        if (col_idx_q == LastIdx) begin
          out_d   = work_d;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d    = state_in;
            col_idx_d = '0;
            state_d   = StBusy;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      work_q    <= '0;
      col_idx_q <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      col_idx_q <= col_idx_d;
      out_q     <= out_d;
    end
  end

  assign state_out = out_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: three instances (1, 2, 4 columns per cycle) checked
// against a matrix-form GF(2^8) reference model.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] state_in  [3];
  logic [127:0] state_out [3];

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .state_in(state_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .state_out(state_out[0]), .busy(busy[0]));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .state_in(state_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .state_out(state_out[1]), .busy(busy[1]));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .state_in(state_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .state_out(state_out[2]), .busy(busy[2]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Circulant matrix product per column; inv selects InvMixColumns over MixColumns.
  function automatic logic [127:0] mix(input logic [127:0] st, input bit inv);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] res = '0;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(cf[(k - r + 4) % 4], st[127-8*(4*c+k) -: 8]);
        res[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic transact(input int u, input logic [127:0] x, input logic [127:0] exp,
                          input string name);
    int k;
    int lat_exp;
    lat_exp = (u == 0) ? 4 : (u == 1) ? 2 : 1;
    @(negedge clk);
    state_in[u]  = x;
    in_valid[u]  = 1'b1;
    out_ready[u] = 1'b0;
    k = 0;
    while (!in_ready[u] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, " accept"}, 128'(in_ready[u]), 128'(1));
    @(negedge clk);
    in_valid[u] = 1'b0;
    k = 0;
    while (!out_valid[u] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, " latency"}, 128'(k), 128'(lat_exp));
    chk({name, " data"}, state_out[u], exp);
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    chk({name, " valid drop"}, 128'(out_valid[u]), 128'(0));
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dexp;
    string        name;
  } vec_t;

  vec_t         tbl [5];
  logic [127:0] src [3];
  logic [127:0] x, exp_bp, held;
  int           acc, got, cyc;
  logic         seen;

  initial begin
    in_valid  = '0;
    out_ready = '0;
    for (int u = 0; u < 3; u++) state_in[u] = '0;

    tbl[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
               128'hdb135345_f20a225c_01010101_d4d4d4d5, "fips"};
    tbl[1] = '{128'h046681e5_e0cb199a_48f8d37a_2806264c,
               128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, "fips_round1"};
    tbl[2] = '{128'h0, 128'h0, "zero"};
    tbl[3] = '{{4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}, "c6"};
    tbl[4] = '{{4{32'h01010101}}, {4{32'h01010101}}, "ones"};

    // Reset asserted from time 0, checked before any clock edge.
    #3;
    for (int u = 0; u < 3; u++) begin
      chk("reset out_valid", 128'(out_valid[u]), 128'(0));
      chk("reset busy", 128'(busy[u]), 128'(0));
      chk("reset state_out", state_out[u], 128'h0);
    end
    #10 rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) chk("idle in_ready", 128'(in_ready[u]), 128'(1));

    for (int u = 0; u < 3; u++)
      for (int i = 0; i < 5; i++) transact(u, tbl[i].din, tbl[i].dexp, tbl[i].name);

    // Backpressure: result held, new input refused while out_ready is low.
    x = rnd128();
    exp_bp = mix(x, 1'b1);
    @(negedge clk);
    state_in[0] = x;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    cyc = 0;
    while (!out_valid[0] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      state_in[0] = rnd128();
      in_valid[0] = 1'b1;
      chk("bp out_valid", 128'(out_valid[0]), 128'(1));
      chk("bp state_out", state_out[0], exp_bp);
      chk("bp in_ready", 128'(in_ready[0]), 128'(0));
      @(negedge clk);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("bp after out_valid", 128'(out_valid[0]), 128'(0));
    chk("bp not captured", 128'(busy[0]), 128'(0));
    chk("bp state_out kept", state_out[0], exp_bp);

    // Back-to-back with continuous in_valid and out_ready.
    for (int i = 0; i < 3; i++) src[i] = rnd128();
    acc = 0;
    got = 0;
    cyc = 0;
    @(negedge clk);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    state_in[0]  = src[0];
    while (got < 3 && cyc < 100) begin
      if (out_valid[0]) begin
        chk("b2b result", state_out[0], mix(src[got], 1'b1));
        got++;
      end
      if (in_valid[0] && in_ready[0]) begin
        if (acc > 0) chk("b2b accept on transfer", 128'(out_valid[0]), 128'(1));
        acc++;
      end
      @(negedge clk);
      cyc++;
      if (acc < 3) state_in[0] = src[acc];
      else in_valid[0] = 1'b0;
    end
    chk("b2b count", 128'(got), 128'(3));
    repeat (6) begin
      @(negedge clk);
      if (out_valid[0]) got++;
    end
    chk("b2b no duplicate", 128'(got), 128'(3));
    out_ready[0] = 1'b0;

    // Reset two cycles into BUSY: in-flight state discarded.
    held = state_out[0];
    chk("pre-reset state_out nonzero", 128'(held != 128'h0), 128'(1));
    @(negedge clk);
    state_in[0] = rnd128();
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", 128'(busy[0]), 128'(0));
    chk("midreset out_valid", 128'(out_valid[0]), 128'(0));
    chk("midreset state_out", state_out[0], 128'h0);
    chk("midreset in_ready", 128'(in_ready[0]), 128'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    chk("midreset no stale output", 128'(seen), 128'(0));
    transact(0, tbl[0].din, tbl[0].dexp, "after reset");

    // Round trip through MixColumns then the DUT, spread over all three instances.
    for (int i = 0; i < 1000; i++) begin
      x = rnd128();
      transact(i % 3, mix(x, 1'b0), x, "roundtrip");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
